noise_injector: RTL
===================

# noise_injector

Upstream stage of the audio filter path. Accepts a frame of 1024 clean 8-bit unsigned samples over a valid/ready stream and adds switch-scaled pseudo-random distortion from a 16-bit LFSR. Writes each distorted sample into the sample BRAM at sequential addresses 0..1023. Pulses a completion flag so the downstream 5-tap filter stage can start on a fully populated frame.

## Interface
Parameters:
- DATA_W, 8, sample width (unsigned, offset binary)
- ADDR_W, 10, BRAM address width
- DEPTH, 1024, samples per frame (must be ≤ 2^ADDR_W)
- LFSR_SEED, 16'hACE1, LFSR reload value (must be nonzero)

Ports:
- clk  in  1  single system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a frame; honoured only in IDLE
- switches  in  4  [3] noise enable, [2:0] amplitude a (0..7)
- in_valid  in  1  upstream sample valid
- in_data  in  DATA_W  upstream clean sample
- in_ready  out  1  block accepts a sample this cycle
- bram_we  out  1  BRAM write strobe
- bram_addr  out  ADDR_W  BRAM write address
- bram_din  out  DATA_W  distorted sample to BRAM
- busy  out  1  frame in progress (RUN or DONE)
- frame_done  out  1  one-cycle pulse after the last write

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=0. On start, latch switches into sw_q, clear the write index, go to RUN.
  - RUN: in_ready=1. Accept a sample when in_valid&in_ready. The accept that carries index DEPTH-1 moves the FSM to DONE.
  - DONE: in_ready=0. Return to IDLE next cycle.
- sw_q is held for the whole frame; switch changes mid-frame have no effect.
- start outside IDLE is ignored.
- LFSR: 16-bit Galois, right-shifting, toggle mask 16'hB400.
  - Step: lfsr = lfsr[0] ? (lfsr>>1)^16'hB400 : lfsr>>1.
  - Advances once per accepted sample only, never on idle cycles.
  - An accepted sample uses the LFSR value present before that sample's advance.
  - Value is preserved across frames; reloaded only by rst.
- Noise:
  - n = $signed(lfsr[7:0]) >>> (7 - sw_q[2:0]), giving an 8-bit signed value.
  - n = 0 when sw_q[3]=0 (bypass).
- Sum: s = {1'b0,in_data} + sign-extended n, computed as a 10-bit signed value.
- Output value: see Configuration.
- Write index increments by 1 per accept and never wraps within a frame; it is cleared at the next start.

## Timing
- Reset values: in_ready=0, bram_we=0, bram_addr=0, bram_din=0, busy=0, frame_done=0, FSM=IDLE, LFSR=LFSR_SEED, sw_q=0.
- Latency: an accept in cycle k produces bram_we=1 in cycle k+1, with bram_addr equal to that sample's index and the registered bram_din.
- bram_we is high for exactly one cycle per accepted sample. Back-to-back accepts give back-to-back writes at full throughput.
- in_valid without in_ready: no accept, LFSR and index unchanged. Upstream must hold in_data until accepted.
- The final write (addr DEPTH-1) occurs in the first DONE cycle. frame_done pulses in the cycle after that write, coincident with the return to IDLE.
- busy rises the cycle after start is sampled. It falls with the IDLE transition.
- rst mid-frame: all outputs return to reset values next cycle and any pending write is dropped. The partial frame is abandoned and no frame_done is issued.

## Configuration
- NOISE_SATURATE_EN defined: bram_din is s clamped to 0..255 (s<0 gives 8'h00, s>255 gives 8'hFF).
- NOISE_SATURATE_EN undefined: bram_din = s[7:0], i.e. modulo-256 wrap, with no clamp logic.

## Test plan
- Bypass, switches=4'b0000: stream 1024 samples with in_data = index[7:0]. Required: writes at addr 0..1023 with din = in_data; frame_done pulses once, one cycle after the addr-1023 write.
- Full noise, switches=4'b1111, after rst: in_data 8'h40 then 8'hF0. Required: sample 0 noise = −31 (lfsr 16'hACE1), din 8'h21; sample 1 noise = +112 (lfsr 16'hE270), din 8'h60 without the macro, 8'hFF with it.
- Negative clip, switches=4'b1111, after rst: first sample 8'h10. Required: din 8'hF1 without the macro, 8'h00 with it.
- Backpressure: toggle in_valid randomly during a frame. Required: the write count is exactly 1024, addresses are contiguous, and the noise sequence is identical to the gap-free run.
- Switch change mid-frame, 4'b1111 → 4'b0000 at sample 500: no change in noise scaling. Then assert start during RUN: ignored, with no index reset.
- rst at sample 300: bram_we=0 next cycle, no frame_done. A new start then reproduces the sample-0 result 8'h21 for input 8'h40.

Source files
------------

// File: rtl/noise_injector_if.sv
// Sample stream in, BRAM write port out, bundled for the noise_injector.
// The slave modport is the injector's view; master is the upstream/BRAM side.
interface noise_injector_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 10
);
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic              bram_we;
   logic [ADDR_W-1:0] bram_addr;
   logic [DATA_W-1:0] bram_din;

   modport master (
      output in_valid, in_data,
      input  in_ready, bram_we, bram_addr, bram_din
   );

   modport slave (
      input  in_valid, in_data,
      output in_ready, bram_we, bram_addr, bram_din
   );
endinterface

// File: rtl/noise_injector.sv
// Adds switch-scaled LFSR noise to a frame of samples and writes them to BRAM.
// Define NOISE_SATURATE_EN to clamp the sum to 0..max instead of wrapping modulo 2^DATA_W.
module noise_injector #(
   parameter int          DATA_W    = 8,
   parameter int          ADDR_W    = 10,
   parameter int          DEPTH     = 1024,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       switches,
   noise_injector_if.slave  bus,
   output logic             busy,
   output logic             frame_done
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

   state_t            state;
   logic [3:0]        sw_q;
   logic [ADDR_W-1:0] idx;
   logic [15:0]       lfsr;
   logic [15:0]       lfsr_next;
   logic [2:0]        shamt;
   logic signed [7:0] noise;
   logic [DATA_W-1:0] out_val;
   logic              accept;
`ifdef NOISE_SATURATE_EN
   logic [DATA_W+1:0] sum;
`endif

   assign accept    = bus.in_valid && bus.in_ready;
   assign lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
   assign shamt     = 3'd7 - sw_q[2:0];

   // Kept as if/else: a ternary against an unsigned zero would turn >>> into a logical shift.
   always_comb begin
      noise = '0;
      if (sw_q[3]) begin
         noise = $signed(lfsr[7:0]) >>> shamt;
      end
   end

`ifdef NOISE_SATURATE_EN
   always_comb begin
      sum     = {2'b00, bus.in_data} + (DATA_W+2)'(noise);
      out_val = sum[DATA_W-1:0];
      if (sum[DATA_W+1]) begin
         out_val = '0;
      end else if (sum[DATA_W]) begin
         out_val = '1;
      end
   end
`else
   assign out_val = bus.in_data + DATA_W'(noise);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         sw_q          <= '0;
         idx           <= '0;
         lfsr          <= LFSR_SEED;
         bus.in_ready  <= 1'b0;
         bus.bram_we   <= 1'b0;
         bus.bram_addr <= '0;
         bus.bram_din  <= '0;
         busy          <= 1'b0;
         frame_done    <= 1'b0;
      end else begin
         bus.bram_we <= 1'b0;
         frame_done  <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  sw_q         <= switches;
                  idx          <= '0;
                  bus.in_ready <= 1'b1;
                  busy         <= 1'b1;
                  state        <= RUN;
               end
            end
            RUN: begin
               if (accept) begin
                  bus.bram_we   <= 1'b1;
                  bus.bram_addr <= idx;
                  bus.bram_din  <= out_val;
                  lfsr          <= lfsr_next;
                  idx           <= idx + 1'b1;
                  if (idx == LAST_IDX) begin
                     bus.in_ready <= 1'b0;
                     state        <= DONE;
                  end
               end
            end
            DONE: begin
               busy       <= 1'b0;
               frame_done <= 1'b1;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
